// File: rtl/axi_slave_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between a master and axi_slave_wr_ctrl.
interface axi_slave_wr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                      AWVALID;
    logic                      AWREADY;
    logic [ID_WIDTH-1:0]       AWID;
    logic [ADDR_WIDTH-1:0]     AWADDR;
    logic [7:0]                AWLEN;
    logic [2:0]                AWSIZE;
    logic [1:0]                AWBURST;
    logic                      WVALID;
    logic                      WREADY;
    logic [DATA_WIDTH-1:0]     WDATA;
    logic [DATA_WIDTH/8-1:0]   WSTRB;
    logic                      WLAST;
    logic                      BVALID;
    logic                      BREADY;
    logic [ID_WIDTH-1:0]       BID;
    logic [1:0]                BRESP;

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP
    );

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP
    );
endinterface

// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 write-path slave: converts one burst at a time (FIXED/INCR/WRAP) into
// per-beat byte-strobed writes on a simple memory port.
// Optional macro AXI_WR_LAST_CHECK_EN: a WLAST that disagrees with the AWLEN
// beat count turns the response into SLVERR (DECERR keeps priority).
module axi_slave_wr_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = '0,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = ADDR_WIDTH'(32'h0001_0000)
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    axi_slave_wr_ctrl_if.slave      axi,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE   = $clog2(STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    awready_q, wready_q, bvalid_q;
    logic                    awready_nxt, wready_nxt, bvalid_nxt;
    logic [ID_WIDTH-1:0]     id_q, bid_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [7:0]              len_q, beat_cnt;
    logic [2:0]              size_q;
    logic [1:0]              burst_q, resp_q, bresp_q;
    logic [1:0]              aw_resp_c, resp_upd_c;
    logic                    aw_hs, w_hs, b_hs, last_beat;
    logic                    last_err_c;

    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;

    assign aw_hs     = axi.AWVALID & awready_q;
    assign w_hs      = axi.WVALID & wready_q;
    assign b_hs      = bvalid_q & axi.BREADY;
    assign last_beat = (beat_cnt == len_q);

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aw_hs)             state_nxt = DATA;
            DATA:    if (w_hs && last_beat) state_nxt = RESP;
            RESP:    if (b_hs)              state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they register cleanly
    always_comb begin
        awready_nxt = 1'b0;
        wready_nxt  = 1'b0;
        bvalid_nxt  = 1'b0;
        case (state_nxt)
            IDLE:    awready_nxt = 1'b1;
            DATA:    wready_nxt  = 1'b1;
            RESP:    bvalid_nxt  = 1'b1;
            default: awready_nxt = 1'b1;
        endcase
    end

    // Handshake output registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= awready_nxt;
            wready_q  <= wready_nxt;
            bvalid_q  <= bvalid_nxt;
        end
    end

    // Response classification of the incoming AW request
    always_comb begin
        logic [ADDR_WIDTH:0]   aw_ext, win_lo, win_hi;
        logic [ADDR_WIDTH-1:0] aw_sz;
        logic                  in_window, bad_wrap;
        aw_resp_c = RESP_OKAY;
        aw_ext    = {1'b0, axi.AWADDR};
        win_lo    = {1'b0, MEM_BASE};
        win_hi    = win_lo + {1'b0, MEM_SIZE};
        aw_sz     = ADDR_WIDTH'(1) << axi.AWSIZE;
        in_window = (aw_ext >= win_lo) && (aw_ext < win_hi);
        bad_wrap  = (axi.AWBURST == BURST_WRAP) &&
                    (!(axi.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                     ((axi.AWADDR & (aw_sz - ADDR_WIDTH'(1))) != '0));
        if (!in_window)
            aw_resp_c = RESP_DECERR;
        else if ((axi.AWSIZE > 3'(MAX_SIZE)) || (axi.AWBURST == 2'b11) || bad_wrap)
            aw_resp_c = RESP_SLVERR;
    end

    // Beat address sequencing for FIXED/INCR/WRAP
    always_comb begin
        logic [ADDR_WIDTH-1:0] sz, wrap_mask;
        sz        = ADDR_WIDTH'(1) << size_q;
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
            BURST_INCR:  addr_nxt = (addr_q & ~(sz - ADDR_WIDTH'(1))) + sz;
            BURST_WRAP:  addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + sz) & wrap_mask);
            default:     addr_nxt = addr_q;
        endcase
    end

`ifdef AXI_WR_LAST_CHECK_EN
    assign last_err_c = (axi.WLAST != last_beat);
`else
    logic unused_wlast_c;
    assign last_err_c     = 1'b0;
    assign unused_wlast_c = axi.WLAST;
`endif

    // Sticky response: a WLAST mismatch only upgrades an otherwise clean burst
    always_comb begin
        resp_upd_c = resp_q;
        if (w_hs && last_err_c && (resp_q == RESP_OKAY))
            resp_upd_c = RESP_SLVERR;
    end

    // Burst context, beat counter, memory port and B payload
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_cnt  <= '0;
            resp_q    <= RESP_OKAY;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= 1'b0;
            if (aw_hs) begin
                id_q     <= axi.AWID;
                addr_q   <= axi.AWADDR;
                len_q    <= axi.AWLEN;
                size_q   <= axi.AWSIZE;
                burst_q  <= axi.AWBURST;
                beat_cnt <= '0;
                resp_q   <= aw_resp_c;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                addr_q   <= addr_nxt;
                resp_q   <= resp_upd_c;
                if (resp_upd_c == RESP_OKAY) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q - MEM_BASE;
                    mem_wdata <= axi.WDATA;
                    mem_wstrb <= axi.WSTRB;
                end
                if (last_beat) begin
                    bid_q   <= id_q;
                    bresp_q <= resp_upd_c;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_slave_wr_ctrl.sv
// Scoreboard bench for axi_slave_wr_ctrl: stimulus pushes expected memory
// writes and B responses; a negedge monitor pops and compares them.
module tb_axi_slave_wr_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;

    int errors = 0;
    int checks = 0;
    wr_t exp_wr[$];
    b_t  exp_b[$];

    axi_slave_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bif();

    axi_slave_wr_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .MEM_BASE(32'h0000_0000), .MEM_SIZE(32'h0001_0000)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .axi(bif.slave),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every memory write and B handshake must match the scoreboard head
    always @(negedge ACLK) begin
        if (ARESETn && mem_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                chk("mem_write", {mem_addr, mem_wdata}, {e.addr, e.data});
                chk("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
        if (ARESETn && bif.BVALID && bif.BREADY) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bresp actual id=%0h resp=%0h required none", bif.BID, bif.BRESP);
            end else begin
                b_t e;
                e = exp_b.pop_front();
                chk("b_response", {58'd0, bif.BID, bif.BRESP}, {58'd0, e.id, e.resp});
            end
        end
    end

    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bif.AWVALID = 1'b1; bif.AWID = id; bif.AWADDR = addr;
        bif.AWLEN = len; bif.AWSIZE = size; bif.AWBURST = burst;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (bif.AWREADY) begin
                @(posedge ACLK); #1;
                bif.AWVALID = 1'b0;
                return;
            end
        end
        chk("aw_timeout", 64'd0, 64'd1);
        bif.AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bif.WVALID = 1'b1; bif.WDATA = data; bif.WSTRB = strb; bif.WLAST = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (bif.WREADY) begin
                @(posedge ACLK); #1;
                bif.WVALID = 1'b0;
                return;
            end
        end
        chk("w_timeout", 64'd0, 64'd1);
        bif.WVALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && (exp_b.size() != 0 || exp_wr.size() != 0); i++)
            @(posedge ACLK);
        repeat (2) @(posedge ACLK);
        #1;
        chk(name, 64'(exp_b.size() + exp_wr.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {62'd0, bif.AWREADY, bif.WREADY}, 64'h2);
        chk({tag, "_b"}, {57'd0, bif.BVALID, bif.BID, bif.BRESP}, 64'd0);
        chk({tag, "_mem"}, {mem_we, mem_addr, mem_wdata[30:0]}, 64'd0);
        chk({tag, "_mem_hi"}, {59'd0, mem_wdata[31], mem_wstrb}, 64'd0);
    endtask

    initial begin
        bif.AWVALID = 0; bif.AWID = 0; bif.AWADDR = 0; bif.AWLEN = 0; bif.AWSIZE = 0; bif.AWBURST = 0;
        bif.WVALID = 0; bif.WDATA = 0; bif.WSTRB = 0; bif.WLAST = 0; bif.BREADY = 1;
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs("reset");
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // INCR 4 beats of a word
        exp_wr.push_back('{32'h10, 32'hA0, 4'hF}); exp_wr.push_back('{32'h14, 32'hA1, 4'hF});
        exp_wr.push_back('{32'h18, 32'hA2, 4'hF}); exp_wr.push_back('{32'h1C, 32'hA3, 4'hF});
        exp_b.push_back('{4'h5, 2'b00});
        do_aw(4'h5, 32'h10, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) do_w(32'hA0 + 32'(i), 4'hF, i == 3);
        wait_drain("incr_drain");

        // WRAP 16-byte window starting mid-window
        exp_wr.push_back('{32'h38, 32'hB0, 4'hF}); exp_wr.push_back('{32'h3C, 32'hB1, 4'hF});
        exp_wr.push_back('{32'h30, 32'hB2, 4'hF}); exp_wr.push_back('{32'h34, 32'hB3, 4'hF});
        exp_b.push_back('{4'h3, 2'b00});
        do_aw(4'h3, 32'h38, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) do_w(32'hB0 + 32'(i), 4'hF, i == 3);
        wait_drain("wrap_drain");

        // FIXED burst with walking strobes
        exp_wr.push_back('{32'h20, 32'hC0, 4'h1}); exp_wr.push_back('{32'h20, 32'hC1, 4'h2});
        exp_wr.push_back('{32'h20, 32'hC2, 4'h4});
        exp_b.push_back('{4'h7, 2'b00});
        do_aw(4'h7, 32'h20, 8'd2, 3'd2, 2'b00);
        do_w(32'hC0, 4'h1, 1'b0); do_w(32'hC1, 4'h2, 1'b0); do_w(32'hC2, 4'h4, 1'b1);
        wait_drain("fixed_drain");

        // Just outside the window: DECERR, no writes
        exp_b.push_back('{4'h2, 2'b11});
        do_aw(4'h2, 32'h0001_0000, 8'd1, 3'd2, 2'b01);
        do_w(32'hD0, 4'hF, 1'b0); do_w(32'hD1, 4'hF, 1'b1);
        wait_drain("decerr_drain");

        // Oversized beat: SLVERR
        exp_b.push_back('{4'h4, 2'b10});
        do_aw(4'h4, 32'h0, 8'd0, 3'd3, 2'b01);
        do_w(32'hE0, 4'hF, 1'b1);
        wait_drain("size_err_drain");

        // WRAP with illegal length: SLVERR
        exp_b.push_back('{4'h6, 2'b10});
        do_aw(4'h6, 32'h0, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) do_w(32'hE8, 4'hF, i == 2);
        wait_drain("wrap_len_err_drain");

        // Back-pressured response must hold steady
        bif.BREADY = 1'b0;
        exp_wr.push_back('{32'h40, 32'hF0, 4'hF});
        exp_b.push_back('{4'h9, 2'b00});
        do_aw(4'h9, 32'h40, 8'd0, 3'd2, 2'b01);
        do_w(32'hF0, 4'hF, 1'b1);
        begin
            int n = 0;
            while (!bif.BVALID && n < 50) begin @(negedge ACLK); n++; end
            chk("bvalid_rise", 64'(bif.BVALID), 64'd1);
            for (int i = 0; i < 5; i++) begin
                chk("b_hold", {57'd0, bif.BVALID, bif.BID, bif.BRESP}, {57'd0, 1'b1, 4'h9, 2'b00});
                chk("awready_hold", 64'(bif.AWREADY), 64'd0);
                @(negedge ACLK);
            end
        end
        @(posedge ACLK); #1;
        bif.BREADY = 1'b1;
        wait_drain("bhold_drain");

        // Reset mid-burst: two writes land, then everything returns to reset
        exp_wr.push_back('{32'h50, 32'h11, 4'hF}); exp_wr.push_back('{32'h54, 32'h22, 4'hF});
        do_aw(4'h1, 32'h50, 8'd3, 3'd2, 2'b01);
        do_w(32'h11, 4'hF, 1'b0); do_w(32'h22, 4'hF, 1'b0);
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        #2;
        chk_reset_outputs("midburst_reset");
        chk("midburst_writes", 64'(exp_wr.size()), 64'd0);
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Top word of the window after recovery
        exp_wr.push_back('{32'hFFFC, 32'h1234_5678, 4'hF});
        exp_b.push_back('{4'hA, 2'b00});
        do_aw(4'hA, 32'h0000_FFFC, 8'd0, 3'd2, 2'b01);
        do_w(32'h1234_5678, 4'hF, 1'b1);
        wait_drain("top_word_drain");

`ifdef AXI_WR_LAST_CHECK_EN
        // Early WLAST: beat 0 writes, offending and later beats dropped, SLVERR
        exp_wr.push_back('{32'h60, 32'h70, 4'hF});
        exp_b.push_back('{4'hB, 2'b10});
        do_aw(4'hB, 32'h60, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) do_w(32'h70 + 32'(i), 4'hF, i == 1);
        wait_drain("wlast_drain");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_slave_wr_ctrl.md
Name: axi_slave_wr_ctrl

Overview:
AXI4 write-path slave controller. It sits directly downstream of the slave-side AXI interface, drives the AW/W/B slave outputs, and consumes AWxxx/Wxxx. It converts each write burst into per-beat byte-strobed writes on a simple memory port. One outstanding write transaction at a time; FIXED, INCR and WRAP bursts are supported.

Parameters:
ADDR_WIDTH, 32, AXI address width and memory-port address width.
DATA_WIDTH, 32, WDATA width in bits; must be 32, 64 or 128.
ID_WIDTH, 4, AWID/BID width.
MEM_BASE, 32'h0000_0000, lowest byte address decoded by this slave.
MEM_SIZE, 32'h0001_0000, decoded window size in bytes; must be a power of 2.

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
AWID  in  ID_WIDTH  transaction ID
AWADDR  in  ADDR_WIDTH  start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
WVALID  in  1  write data valid
WREADY  out  1  write data ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WLAST  in  1  last beat
BVALID  out  1  response valid
BREADY  in  1  response ready
BID  out  ID_WIDTH  response ID (equals captured AWID)
BRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR
mem_we  out  1  memory write strobe, one cycle per accepted beat
mem_addr  out  ADDR_WIDTH  beat byte address, offset from MEM_BASE
mem_wdata  out  DATA_WIDTH  registered WDATA
mem_wstrb  out  DATA_WIDTH/8  registered WSTRB

Behaviour:
- Reset (async assert, sync release) puts the FSM in IDLE.
  - AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00.
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Reset mid-burst abandons the burst; no partial response is issued.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1.
  - On AWVALID&AWREADY: capture AWID/AWADDR/AWLEN/AWSIZE/AWBURST, set beat counter=0, compute the error flag, go to DATA.
  - AWREADY drops the following cycle.
- Error flag computed at AW capture:
  - DECERR if AWADDR is outside [MEM_BASE, MEM_BASE+MEM_SIZE).
  - Otherwise SLVERR if any of:
    - AWSIZE > log2(DATA_WIDTH/8);
    - AWBURST=11;
    - WRAP with AWLEN not in {1,3,7,15};
    - WRAP with AWADDR unaligned to the size.
  - DECERR takes priority over SLVERR.
- DATA:
  - WREADY=1. Each W handshake increments the beat counter.
  - If no error: mem_we=1 in the next cycle, with mem_addr=current address-MEM_BASE and registered WDATA/WSTRB.
  - If error: beats are accepted and discarded, mem_we stays 0.
  - WSTRB is passed through unmodified; narrow-lane correctness is the master's responsibility.
  - The burst ends on the beat where counter==AWLEN. WREADY drops, go to RESP.
- Address update after each beat; sz = 1<<AWSIZE:
  - FIXED: address held.
  - INCR: next = (addr & ~(sz-1)) + sz, computed at ADDR_WIDTH and wrapping modulo 2^ADDR_WIDTH. No 4 KB check.
  - WRAP: boundary = addr & ~((AWLEN+1)*sz-1). next = boundary + ((addr+sz-boundary) mod ((AWLEN+1)*sz)).
- RESP:
  - BVALID=1 with BID=captured AWID and BRESP=OKAY/SLVERR/DECERR.
  - BVALID stays high and BID/BRESP stay stable until BREADY. On BVALID&BREADY go to IDLE; AWREADY=1 the next cycle.
  - BREADY already high when BVALID rises gives a one-cycle response.
- Minimum burst turnaround: AW cycle, then AWLEN+1 W cycles, then one B cycle.
- AW and W do not overlap: W beats presented before AW capture are not accepted (WREADY=0).

Optional Feature:
AXI_WR_LAST_CHECK_EN
- Defined:
  - WLAST=1 on a beat with counter<AWLEN, or WLAST=0 on the final counted beat, sets the sticky SLVERR.
  - Writes already issued are not undone.
  - The burst still terminates on counter==AWLEN.
  - DECERR retains priority.
- Undefined: WLAST is ignored; burst length is governed solely by AWLEN.

Test Plan:
- INCR, AWADDR=0x10, AWLEN=3, AWSIZE=2, WDATA 0xA0..0xA3, WSTRB=F, BREADY=1 -> mem_we pulses at mem_addr 0x10,0x14,0x18,0x1C with matching data; BRESP=00, BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> mem_addr sequence 0x38,0x3C,0x30,0x34; BRESP=00.
- FIXED, AWADDR=0x20, AWLEN=2, WSTRB 1,2,4 -> three writes all at mem_addr 0x20 with the given strobes.
- Address beyond the window (MEM_BASE+MEM_SIZE), AWLEN=1 -> two beats accepted, mem_we never asserted, BRESP=11.
- Error cases -> BRESP=10, no writes:
  - AWSIZE=3 with DATA_WIDTH=32;
  - WRAP with AWLEN=2.
- Hold BREADY=0 for 5 cycles after BVALID -> BVALID, BID, BRESP stable and AWREADY=0 throughout.
- Assert ARESETn=0 mid-burst -> all outputs return to reset values.
- With AXI_WR_LAST_CHECK_EN: AWLEN=3 with WLAST on beat 1 -> 4 beats accepted, BRESP=10.
